mult_div_sequencer: RTL and testbench



---
 rtl/mult_div_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Multicycle MULT/DIV sequencer for the HI/LO registers: 32-step radix-2 Booth
// multiply or restoring divide on magnitudes with a final sign-fix cycle.
module mult_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Booth step datapath; the accumulator carries one guard bit so that
  // subtracting the most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc_sum, acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic             qm1_nx;

  always_comb begin
    acc_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + mcand_q;
      2'b10:   acc_sum = acc_q - mcand_q;
      default: acc_sum = acc_q;
    endcase
    acc_nx = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mq_nx  = {acc_sum[0], mq_q[WIDTH-1:1]};
    qm1_nx = mq_q[0];
  end

  // Restoring divide step on magnitudes.
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dmag_q};
    rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

  // Unsigned magnitudes; 0x80..0 maps to itself, which is the correct value.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  logic can_launch;
  assign can_launch = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (can_launch) begin
          cnt_d = CNT_LOAD;
          if (!op) begin
            acc_d   = '0;
            mcand_d = {a[WIDTH-1], a};
            mq_d    = b;
            qm1_d   = 1'b0;
            state_d = S_MULT;
          end else if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dmag_d  = b_mag;
            qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d  = a[WIDTH-1];
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        qm1_d = qm1_nx;
        if (cnt_q == '0) begin
          hi_d    = acc_nx[WIDTH-1:0];
          lo_d    = mq_nx;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed corners plus random ops
// against a plain-arithmetic 64-bit reference.
module tb_mult_div_sequencer;
  logic        clock, reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // returns {remainder, quotient}; 64-bit math makes most-negative / -1 well defined
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    longint xa, ya, q, r;
    xa = longint'($signed(x));
    ya = longint'($signed(y));
    q = xa / ya;
    r = xa % ya;
    return {r[31:0], q[31:0]};
  endfunction

  // Launch one op, scramble inputs afterwards, optionally pulse start at cycle inj.
  task automatic run_op(input logic opv, input logic [31:0] av, input logic [31:0] bv,
                        input int inj, output int dcyc, output int bcnt,
                        output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output logic stable);
    logic [31:0] h0, l0;
    @(negedge clock);
    h0 = hi; l0 = lo;
    start = 1'b1; op = opv; a = av; b = bv;
    dcyc = -1; bcnt = 0; stable = 1'b1; h = hi; l = lo; dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      start = (c == inj);
      op = ~opv; a = $urandom; b = $urandom;
      if (busy) bcnt++;
      if (!done && (hi !== h0 || lo !== l0)) stable = 1'b0;
      if (done) begin
        dcyc = c; h = hi; l = lo; dz = div_zero;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done, div_zero); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult;
    logic [31:0] ta[3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb[3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [63:0] ex[3] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000000_00000001};
    int dc, bc; logic [31:0] h, l; logic dz, st;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ta[i], tb[i], 0, dc, bc, h, l, dz, st);
      total++; if (dc !== 33) begin bad++; $display("FAIL mult_latency[%0d] got=%0d exp=33", i, dc); end
      total++; if (bc !== 32) begin bad++; $display("FAIL mult_busy[%0d] got=%0d exp=32", i, bc); end
      total++; if ({h, l} !== ex[i]) begin bad++; $display("FAIL mult_result[%0d] got=%h_%h exp=%h", i, h, l, ex[i]); end
      total++; if (!st) begin bad++; $display("FAIL mult_hilo_hold[%0d] got=changed exp=held", i); end
      {m_hi, m_lo} = ex[i];
    end
  endtask

  task automatic test_div;
    logic [31:0] ta[3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] tb[3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [63:0] ex[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000};
    int dc, bc; logic [31:0] h, l; logic dz, st;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, ta[i], tb[i], 0, dc, bc, h, l, dz, st);
      total++; if (dc !== 34) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=34", i, dc); end
      total++; if (bc !== 33) begin bad++; $display("FAIL div_busy[%0d] got=%0d exp=33", i, bc); end
      total++; if ({h, l} !== ex[i] || dz !== 1'b0) begin bad++; $display("FAIL div_result[%0d] got=%h_%h dz=%b exp=%h dz=0", i, h, l, dz, ex[i]); end
      {m_hi, m_lo} = ex[i];
    end
  endtask

  task automatic test_div_zero;
    int dc, bc; logic [31:0] h, l; logic dz, st;
    // 0x692 / 0x20 = 0x34 rem 0x12 leaves known values in HI/LO
    run_op(1'b1, 32'h692, 32'h20, 0, dc, bc, h, l, dz, st);
    total++; if (h !== 32'h12 || l !== 32'h34) begin bad++; $display("FAIL dz_setup got=%h/%h exp=12/34", h, l); end
    run_op(1'b1, 32'd5, 32'd0, 0, dc, bc, h, l, dz, st);
    total++; if (dc !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", dc); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    total++; if (bc !== 0) begin bad++; $display("FAIL dz_busy got=%0d exp=0", bc); end
    total++; if (h !== 32'h12 || l !== 32'h34) begin bad++; $display("FAIL dz_hilo got=%h/%h exp=12/34", h, l); end
    @(negedge clock);
    total++; if (div_zero !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL dz_pulse got=%b%b exp=00", done, div_zero); end
    m_hi = 32'h12; m_lo = 32'h34;
  endtask

  task automatic test_start_ignored;
    int dc, bc; logic [31:0] h, l; logic dz, st;
    run_op(1'b0, 32'h12345678, 32'hFEDCBA98, 5, dc, bc, h, l, dz, st);
    total++; if (dc !== 33) begin bad++; $display("FAIL ignore_latency got=%0d exp=33", dc); end
    total++; if ({h, l} !== ref_mul(32'h12345678, 32'hFEDCBA98)) begin bad++; $display("FAIL ignore_result got=%h_%h exp=%h", h, l, ref_mul(32'h12345678, 32'hFEDCBA98)); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%b exp=0", busy); end
    {m_hi, m_lo} = ref_mul(32'h12345678, 32'hFEDCBA98);
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    logic [63:0] r1, r2;
    c1 = -1; c2 = -1; r1 = '0; r2 = '0;
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'hFFFF0001; b = 32'h00012345;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        c1 = c; r1 = {hi, lo};
        start = 1'b1; op = 1'b1; a = 32'h8000_0001; b = 32'd7;
        break;
      end
    end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin c2 = c; r2 = {hi, lo}; break; end
    end
    total++; if (c1 !== 33 || r1 !== ref_mul(32'hFFFF0001, 32'h00012345)) begin bad++; $display("FAIL b2b_first got=%0d %h exp=33 %h", c1, r1, ref_mul(32'hFFFF0001, 32'h00012345)); end
    total++; if (c2 !== 34 || r2 !== ref_div(32'h80000001, 32'd7)) begin bad++; $display("FAIL b2b_second got=%0d %h exp=34 %h", c2, r2, ref_div(32'h80000001, 32'd7)); end
    m_hi = r2[63:32]; m_lo = r2[31:0];
    if (c2 < 0) begin m_hi = 32'h0; m_lo = 32'h0; end
  endtask

  task automatic test_reset_mid;
    int dc, bc; logic [31:0] h, l; logic dz, st;
    int seen;
    seen = 0;
    @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) seen++;
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midreset_state got=%b %h/%h exp=0 0/0", busy, hi, lo); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_nodone got=%0d exp=0", seen); end
    run_op(1'b1, 32'd1000, 32'hFFFFFFFD, 0, dc, bc, h, l, dz, st);
    total++; if (dc !== 34 || {h, l} !== ref_div(32'd1000, 32'hFFFFFFFD)) begin bad++; $display("FAIL midreset_after got=%0d %h_%h exp=34 %h", dc, h, l, ref_div(32'd1000, 32'hFFFFFFFD)); end
    {m_hi, m_lo} = ref_div(32'd1000, 32'hFFFFFFFD);
  endtask

  task automatic test_random;
    int dc, bc; logic [31:0] h, l; logic dz, st;
    logic opv; logic [31:0] av, bv; logic [63:0] exp_r; int exp_c; logic exp_dz;
    for (int i = 0; i < 24; i++) begin
      opv = 1'(($urandom_range(0, 1)));
      av = $urandom; bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = 32'h0;
        1: av = 32'h80000000;
        2: bv = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (opv == 1'b0)     begin exp_r = ref_mul(av, bv); exp_c = 33; exp_dz = 1'b0; end
      else if (bv == 0)    begin exp_r = {m_hi, m_lo};    exp_c = 1;  exp_dz = 1'b1; end
      else                 begin exp_r = ref_div(av, bv); exp_c = 34; exp_dz = 1'b0; end
      run_op(opv, av, bv, 0, dc, bc, h, l, dz, st);
      total++; if (dc !== exp_c || dz !== exp_dz || {h, l} !== exp_r) begin
        bad++; $display("FAIL rand[%0d] op=%b a=%h b=%h got=%0d dz=%b %h_%h exp=%0d dz=%b %h", i, opv, av, bv, dc, dz, h, l, exp_c, exp_dz, exp_r);
      end
      {m_hi, m_lo} = exp_r;
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
